// File: rtl/alu_pkg.sv
// Shared command codes, FSM state encoding and widths for the sequential ALU.
package alu_pkg;

    localparam int unsigned CMD_W = 4;

    localparam logic [CMD_W-1:0] CMD_ADD  = 4'd0;
    localparam logic [CMD_W-1:0] CMD_SUB  = 4'd1;
    localparam logic [CMD_W-1:0] CMD_XOR  = 4'd2;
    localparam logic [CMD_W-1:0] CMD_SLT  = 4'd3;
    localparam logic [CMD_W-1:0] CMD_AND  = 4'd4;
    localparam logic [CMD_W-1:0] CMD_NAND = 4'd5;
    localparam logic [CMD_W-1:0] CMD_NOR  = 4'd6;
    localparam logic [CMD_W-1:0] CMD_OR   = 4'd7;
    localparam logic [CMD_W-1:0] CMD_SLTU = 4'd8;
    localparam logic [CMD_W-1:0] CMD_MUL  = 4'd9;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_e;

endpackage

// File: rtl/alu_comb_core.sv
// Combinational datapath for every single-cycle command plus illegal-command decode.
module alu_comb_core
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [CMD_W-1:0] cmd_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] result_c,
    output logic             carry_c,
    output logic             ovf_c,
    output logic             err_c
);

    logic             sub;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             c_into_msb;
    logic             ovf;

    // One shared adder: SUB, SLT and SLTU all compute A + ~B + 1
    assign sub   = (cmd_i == CMD_SUB) || (cmd_i == CMD_SLT) || (cmd_i == CMD_SLTU);
    assign b_eff = sub ? ~b_i : b_i;
    assign {cout, sum} = (WIDTH+1)'({1'b0, a_i}) + (WIDTH+1)'({1'b0, b_eff})
                       + (WIDTH+1)'(sub);
    assign c_into_msb = a_i[WIDTH-1] ^ b_eff[WIDTH-1] ^ sum[WIDTH-1];
    assign ovf        = c_into_msb ^ cout;

    always_comb begin
        result_c = '0;
        carry_c  = 1'b0;
        ovf_c    = 1'b0;
        err_c    = 1'b0;
        case (cmd_i)
            CMD_ADD, CMD_SUB: begin
                result_c = sum;
                carry_c  = cout;
                ovf_c    = ovf;
            end
            CMD_XOR:  result_c = a_i ^ b_i;
            CMD_SLT: begin
                result_c = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ ovf};
                carry_c  = cout;
                ovf_c    = ovf;
            end
            CMD_AND:  result_c = a_i & b_i;
            CMD_NAND: result_c = ~(a_i & b_i);
            CMD_NOR:  result_c = ~(a_i | b_i);
            CMD_OR:   result_c = a_i | b_i;
            CMD_SLTU: result_c = {{(WIDTH-1){1'b0}}, ~cout};
            CMD_MUL:  result_c = '0;
            default:  err_c    = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_seq_unit.sv
// Registered ALU with valid/ready handshake and an iterative shift-add multiplier.
module alu_seq_unit
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [CMD_W-1:0] cmd,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carryout,
    output logic             zero,
    output logic             overflow,
    output logic             err
);

    localparam int unsigned ACC_W = 2 * WIDTH;

    state_e             state_q,     state_d;
    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   result_q,    result_d;
    logic               carry_q,     carry_d;
    logic               zero_q,      zero_d;
    logic               ovf_q,       ovf_d;
    logic               err_q,       err_d;
    logic [WIDTH-1:0]   mcand_q,     mcand_d;
    logic [WIDTH-1:0]   mplier_q,    mplier_d;
    logic [ACC_W-1:0]   acc_q,       acc_d;
    logic [CNT_W-1:0]   cnt_q,       cnt_d;

    logic [WIDTH-1:0]   core_result;
    logic               core_carry;
    logic               core_ovf;
    logic               core_err;
    logic               fire_in;
    logic               fire_out;
    logic [ACC_W-1:0]   acc_sum;

    alu_comb_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .cmd_i    (cmd),
        .a_i      (operand_a),
        .b_i      (operand_b),
        .result_c (core_result),
        .carry_c  (core_carry),
        .ovf_c    (core_ovf),
        .err_c    (core_err)
    );

    // A new op may enter in the same cycle the current result drains
    assign in_ready = rst_n && (state_q == IDLE) && (!out_valid_q || out_ready);
    assign fire_in  = in_valid && in_ready;
    assign fire_out = out_valid_q && out_ready;

    assign acc_sum = acc_q + (mplier_q[0] ? (ACC_W'(mcand_q) << cnt_q) : '0);

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign carryout  = carry_q;
    assign zero      = zero_q;
    assign overflow  = ovf_q;
    assign err       = err_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            carry_q     <= 1'b0;
            zero_q      <= 1'b0;
            ovf_q       <= 1'b0;
            err_q       <= 1'b0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            carry_q     <= carry_d;
            zero_q      <= zero_d;
            ovf_q       <= ovf_d;
            err_q       <= err_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        carry_d     = carry_q;
        zero_d      = zero_q;
        ovf_d       = ovf_q;
        err_d       = err_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;

        case (state_q)
            IDLE: begin
                if (fire_in && (cmd == CMD_MUL)) begin
                    state_d     = MUL;
                    out_valid_d = 1'b0;
                    mcand_d     = operand_a;
                    mplier_d    = operand_b;
                    acc_d       = '0;
                    cnt_d       = '0;
                end else if (fire_in) begin
                    out_valid_d = 1'b1;
                    result_d    = core_result;
                    carry_d     = core_carry;
                    zero_d      = ~|core_result;
                    ovf_d       = core_ovf;
                    err_d       = core_err;
                end else if (fire_out) begin
                    out_valid_d = 1'b0;
                end
            end
            MUL: begin
                acc_d    = acc_sum;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CNT_W'(1);
                // Last partial product: publish the low half, flag any high-half bits
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b1;
                    result_d    = acc_sum[WIDTH-1:0];
                    carry_d     = 1'b0;
                    zero_d      = ~|acc_sum[WIDTH-1:0];
                    ovf_d       = |acc_sum[ACC_W-1:WIDTH];
                    err_d       = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_alu_seq_unit.sv
// Directed bench for alu_seq_unit: a 32-bit and an 8-bit instance on a shared clock/reset.
module tb_alu_seq_unit;

    logic        clk;
    logic        rst_n;

    logic        iv32, ir32, ov32, or32, co32, z32, of32, er32;
    logic [3:0]  cmd32;
    logic [31:0] a32, b32, res32;

    logic        iv8, ir8, ov8, or8, co8, z8, of8, er8;
    logic [3:0]  cmd8;
    logic [7:0]  a8, b8, res8;

    int checks   = 0;
    int failures = 0;

    alu_seq_unit #(.WIDTH(32)) dut32 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv32), .in_ready(ir32), .cmd(cmd32),
        .operand_a(a32), .operand_b(b32),
        .out_valid(ov32), .out_ready(or32),
        .result(res32), .carryout(co32), .zero(z32), .overflow(of32), .err(er32)
    );

    alu_seq_unit #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv8), .in_ready(ir8), .cmd(cmd8),
        .operand_a(a8), .operand_b(b8),
        .out_valid(ov8), .out_ready(or8),
        .result(res8), .carryout(co8), .zero(z8), .overflow(of8), .err(er8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Present an op, wait (bounded) for in_ready, return at edge+1 after acceptance
    task automatic issue32(input string tag, input logic [3:0] c,
                           input logic [31:0] a, input logic [31:0] b);
        int n;
        cmd32 = c; a32 = a; b32 = b; iv32 = 1'b1;
        #1;
        n = 0;
        while (!ir32 && n < 50) begin
            @(posedge clk); #1; n++;
        end
        chk({tag, "_ready"}, 64'(ir32), 64'd1);
        @(posedge clk); #1;
        iv32 = 1'b0;
    endtask

    task automatic issue8(input string tag, input logic [3:0] c,
                          input logic [7:0] a, input logic [7:0] b);
        int n;
        cmd8 = c; a8 = a; b8 = b; iv8 = 1'b1;
        #1;
        n = 0;
        while (!ir8 && n < 50) begin
            @(posedge clk); #1; n++;
        end
        chk({tag, "_ready"}, 64'(ir8), 64'd1);
        @(posedge clk); #1;
        iv8 = 1'b0;
    endtask

    task automatic out32(input string tag, input logic [31:0] r, input logic co,
                         input logic z, input logic of, input logic er);
        chk({tag, "_valid"}, 64'(ov32), 64'd1);
        chk({tag, "_result"}, 64'(res32), 64'(r));
        chk({tag, "_carry"}, 64'(co32), 64'(co));
        chk({tag, "_zero"}, 64'(z32), 64'(z));
        chk({tag, "_ovf"}, 64'(of32), 64'(of));
        chk({tag, "_err"}, 64'(er32), 64'(er));
    endtask

    task automatic out8(input string tag, input logic [7:0] r, input logic co,
                        input logic z, input logic of, input logic er);
        chk({tag, "_valid"}, 64'(ov8), 64'd1);
        chk({tag, "_result"}, 64'(res8), 64'(r));
        chk({tag, "_carry"}, 64'(co8), 64'(co));
        chk({tag, "_zero"}, 64'(z8), 64'(z));
        chk({tag, "_ovf"}, 64'(of8), 64'(of));
        chk({tag, "_err"}, 64'(er8), 64'(er));
    endtask

    initial begin
        int lat;
        logic busy_bad;
        logic stable;
        logic quiet;

        rst_n = 1'b0;
        iv32 = 1'b0; or32 = 1'b1; cmd32 = '0; a32 = '0; b32 = '0;
        iv8  = 1'b0; or8  = 1'b1; cmd8  = '0; a8  = '0; b8  = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 64'(ov32), 64'd0);
        chk("rst_result", 64'(res32), 64'd0);
        chk("rst_err", 64'(er32), 64'd0);
        chk("rst_in_ready_low", 64'(ir32), 64'd0);
        chk("rst_valid8", 64'(ov8), 64'd0);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready_release", 64'(ir32), 64'd1);

        // Signed overflow on ADD
        issue32("add_ovf", 4'd0, 32'h7FFF_FFFF, 32'h0000_0001);
        out32("add_ovf", 32'h8000_0000, 1'b0, 1'b0, 1'b1, 1'b0);

        // SUB / SLT / SLTU, each back-to-back with the previous drain
        issue32("sub_eq", 4'd1, 32'd5, 32'd5);
        out32("sub_eq", 32'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        issue32("slt", 4'd3, 32'h8000_0000, 32'h0000_0001);
        out32("slt", 32'd1, 1'b1, 1'b0, 1'b1, 1'b0);
        issue32("sltu", 4'd8, 32'h8000_0000, 32'h0000_0001);
        out32("sltu", 32'd0, 1'b0, 1'b1, 1'b0, 1'b0);

        // MUL with product 2^32: latency and busy window
        issue32("mul_big", 4'd9, 32'h0001_0000, 32'h0001_0000);
        chk("mul_big_busy_start", 64'(ir32), 64'd0);
        lat = 0; busy_bad = 1'b0;
        while (!ov32 && lat < 100) begin
            @(posedge clk); #1; lat++;
            if (!ov32 && ir32) busy_bad = 1'b1;
        end
        chk("mul_big_latency", 64'(lat), 64'd32);
        chk("mul_big_busy", 64'(busy_bad), 64'd0);
        out32("mul_big", 32'd0, 1'b0, 1'b1, 1'b1, 1'b0);

        issue32("mul_small", 4'd9, 32'd7, 32'd6);
        lat = 0;
        while (!ov32 && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
        chk("mul_small_latency", 64'(lat), 64'd32);
        out32("mul_small", 32'd42, 1'b0, 1'b0, 1'b0, 1'b0);

        // Backpressure on an XOR result with an AND queued behind it
        issue32("xor", 4'd2, 32'hF0F0_F0F0, 32'hFFFF_0000);
        out32("xor", 32'h0F0F_F0F0, 1'b0, 1'b0, 1'b0, 1'b0);
        or32 = 1'b0;
        #1;
        chk("bp_in_ready_low", 64'(ir32), 64'd0);
        stable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin
                cmd32 = 4'd4; a32 = 32'hF0F0_F0F0; b32 = 32'hFFFF_0000; iv32 = 1'b1;
            end
            @(posedge clk); #1;
            if (!ov32 || res32 !== 32'h0F0F_F0F0 || ir32 || co32 || z32 || of32 || er32)
                stable = 1'b0;
        end
        chk("bp_stable", 64'(stable), 64'd1);
        or32 = 1'b1;
        #1;
        chk("bp_ready_on_drain", 64'(ir32), 64'd1);
        @(posedge clk); #1;
        iv32 = 1'b0;
        out32("and_after_drain", 32'hF0F0_0000, 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset during a MUL: abort, all outputs cleared, no late result
        issue32("mul_abort", 4'd9, 32'd3, 32'd5);
        repeat (8) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("mrst_valid", 64'(ov32), 64'd0);
        chk("mrst_result", 64'(res32), 64'd0);
        chk("mrst_carry", 64'(co32), 64'd0);
        chk("mrst_zero", 64'(z32), 64'd0);
        chk("mrst_ovf", 64'(of32), 64'd0);
        chk("mrst_err", 64'(er32), 64'd0);
        chk("mrst_in_ready", 64'(ir32), 64'd0);
        rst_n = 1'b1;
        #1;
        chk("mrst_idle", 64'(ir32), 64'd1);
        quiet = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (ov32 || !ir32) quiet = 1'b0;
        end
        chk("mrst_no_result", 64'(quiet), 64'd1);
        issue32("add_after_rst", 4'd0, 32'd1, 32'd2);
        out32("add_after_rst", 32'd3, 1'b0, 1'b0, 1'b0, 1'b0);

        // WIDTH=8 instance: illegal cmd, NOR, multiply overflow
        issue8("illegal8", 4'd12, 8'h5A, 8'hA5);
        out8("illegal8", 8'h00, 1'b0, 1'b1, 1'b0, 1'b1);
        issue8("nor8", 4'd6, 8'h00, 8'h00);
        out8("nor8", 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
        issue8("mul8", 4'd9, 8'h10, 8'h10);
        chk("mul8_busy_start", 64'(ir8), 64'd0);
        lat = 0;
        while (!ov8 && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
        chk("mul8_latency", 64'(lat), 64'd8);
        out8("mul8", 8'h00, 1'b0, 1'b1, 1'b1, 1'b0);

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
